// File: rtl/cla_adder_share_arbiter.sv
// Shares one pipelined CLA adder among NUM_REQ requesters: round-robin grant, latency-matched tag pipe, pause/drain FSM.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module cla_adder_share_arbiter #(
   parameter int DATA_WID  = 32,
   parameter int NUM_REQ   = 4,
   parameter int ADDER_LAT = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DATA_WID-1:0] req_in1,
   input  logic [NUM_REQ*DATA_WID-1:0] req_in2,
   input  logic [NUM_REQ-1:0]          req_carry_in,
   output logic [DATA_WID-1:0]         add_in1,
   output logic [DATA_WID-1:0]         add_in2,
   output logic                        add_carry_in,
   input  logic [DATA_WID-1:0]         add_sum,
   input  logic                        add_carry_out,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_WID-1:0]         rsp_sum,
   output logic                        rsp_carry_out,
   input  logic                        pause,
   output logic                        idle
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int SUM_W = IDX_W + 1;
   localparam int TAG_W = ADDER_LAT * IDX_W;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HALTED
   } state_t;

   state_t               r_state;
   logic                 r_idle;
   logic [ADDER_LAT-1:0] r_tag_valid;
   logic [TAG_W-1:0]     r_tag_idx;
   logic                 w_issue_ok;
   logic                 w_grant_any;
   logic [IDX_W-1:0]     w_grant_idx;
   logic [ADDER_LAT-1:0] w_next_valid;
   logic [IDX_W-1:0]     w_last_idx;

   // Reset is folded in so no handshake or response leaks out while reset is held.
   assign w_issue_ok = (r_state == ST_RUN) && !pause && !reset;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
      w_next_valid = '0;
      w_next_valid = (r_tag_valid << 1) | ADDER_LAT'(w_grant_any);
   end

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_issue_ok && !w_grant_any && req_valid[IDX_W'(i)]) begin
            w_grant_any = 1'b1;
            w_grant_idx = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] r_rr_ptr;

   always_comb begin
      logic [SUM_W-1:0] v_pos;
      w_grant_any = 1'b0;
      w_grant_idx = '0;
      v_pos       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         v_pos = {1'b0, r_rr_ptr} + SUM_W'(i);
         if (v_pos >= SUM_W'(NUM_REQ)) begin
            v_pos = v_pos - SUM_W'(NUM_REQ);
         end
         if (w_issue_ok && !w_grant_any && req_valid[v_pos[IDX_W-1:0]]) begin
            w_grant_any = 1'b1;
            w_grant_idx = v_pos[IDX_W-1:0];
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         r_rr_ptr <= '0;
      end else if (w_grant_any) begin
         r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
      end
   end
`endif

   always_comb begin
      req_ready    = '0;
      add_in1      = '0;
      add_in2      = '0;
      add_carry_in = 1'b0;
      if (w_grant_any) begin
         req_ready[w_grant_idx] = 1'b1;
         add_in1                = req_in1[int'(w_grant_idx) * DATA_WID +: DATA_WID];
         add_in2                = req_in2[int'(w_grant_idx) * DATA_WID +: DATA_WID];
         add_carry_in           = req_carry_in[w_grant_idx];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_idle      <= 1'b0;
         r_tag_valid <= '0;
      end else begin
         r_tag_valid <= w_next_valid;
         case (r_state)
            ST_RUN: begin
               if (pause) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!pause) begin
                  r_state <= ST_RUN;
               end else if (w_next_valid == '0) begin
                  r_state <= ST_HALTED;
                  r_idle  <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (!pause) begin
                  r_state <= ST_RUN;
                  r_idle  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_idle  <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: tag indices are qualified by r_tag_valid, so this datapath shift register carries no reset.
   always_ff @(posedge clock) begin
      r_tag_idx <= (r_tag_idx << IDX_W) | TAG_W'(w_grant_idx);
   end

   assign w_last_idx    = r_tag_idx[TAG_W-1 -: IDX_W];
   assign rsp_valid     = (r_tag_valid[ADDER_LAT-1] && !reset) ? (NUM_REQ'(1) << w_last_idx) : '0;
   assign rsp_sum       = add_sum;
   assign rsp_carry_out = add_carry_out;
   assign idle          = r_idle;

endmodule

// File: tb/tb_cla_adder_share_arbiter.sv
// Self-checking bench for cla_adder_share_arbiter: directed steps plus random traffic scored
// against a cycle-indexed reference of grants, response slots and pause/drain behaviour.
module tb_cla_adder_share_arbiter;
   localparam int DW  = 32;
   localparam int NR  = 4;
   localparam int LAT = 2;
   localparam int IW  = 2;

   logic             clock;
   logic             reset;
   logic             pause;
   logic             idle;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR-1:0]    req_carry_in;
   logic [NR-1:0]    rsp_valid;
   logic [NR*DW-1:0] req_in1;
   logic [NR*DW-1:0] req_in2;
   logic [DW-1:0]    add_in1;
   logic [DW-1:0]    add_in2;
   logic             add_carry_in;
   logic [DW-1:0]    add_sum;
   logic             add_carry_out;
   logic [DW-1:0]    rsp_sum;
   logic             rsp_carry_out;

   // Stand-in for the shared adder: result appears LAT cycles after operands are driven, no reset.
   logic [DW:0] add_p1;
   logic [DW:0] add_p2;
   always_ff @(posedge clock) begin
      add_p1 <= {1'b0, add_in1} + {1'b0, add_in2} + (DW + 1)'(add_carry_in);
      add_p2 <= add_p1;
   end
   assign {add_carry_out, add_sum} = add_p2;

   cla_adder_share_arbiter #(.DATA_WID(DW), .NUM_REQ(NR), .ADDER_LAT(LAT)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_in1      (req_in1),
      .req_in2      (req_in2),
      .req_carry_in (req_carry_in),
      .add_in1      (add_in1),
      .add_in2      (add_in2),
      .add_carry_in (add_carry_in),
      .add_sum      (add_sum),
      .add_carry_out(add_carry_out),
      .rsp_valid    (rsp_valid),
      .rsp_sum      (rsp_sum),
      .rsp_carry_out(rsp_carry_out),
      .pause        (pause),
      .idle         (idle)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] op_a [NR];
   logic [DW-1:0] op_b [NR];
   logic          op_c [NR];

   // Reference: next requester in rotation, pause/halt flags, and expected responses per future cycle.
   int         m_ptr;
   bit         m_draining;
   bit         m_halted;
   logic [7:0] m_cyc;
   bit         m_rv   [256];
   int         m_ridx [256];
   logic [DW:0] m_rsum [256];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NR; i++) begin
         op_a[IW'(i)] = $urandom;
         op_b[IW'(i)] = $urandom;
         op_c[IW'(i)] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic step(input logic [NR-1:0] v, input logic p, input logic rst);
      int            g;
      int            j;
      logic [NR-1:0] e_ready;
      logic [NR-1:0] e_rsp;
      logic [DW-1:0] e1;
      logic [DW-1:0] e2;
      logic          ec;
      logic [DW:0]   full;
      bit            pending;
      logic [7:0]    s;
      req_valid = v;
      pause     = p;
      reset     = rst;
      for (int i = 0; i < NR; i++) begin
         req_in1[i*DW +: DW]      = op_a[IW'(i)];
         req_in2[i*DW +: DW]      = op_b[IW'(i)];
         req_carry_in[IW'(i)]     = op_c[IW'(i)];
      end
      #1;
      g = -1;
      if (!rst && !m_draining && !m_halted && !p) begin
         for (int k = 0; k < NR; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            j = k;
`else
            j = (m_ptr + k) % NR;
`endif
            if (g < 0 && v[IW'(j)]) g = j;
         end
      end
      e_ready = '0;
      e1      = '0;
      e2      = '0;
      ec      = 1'b0;
      if (g >= 0) begin
         e_ready[IW'(g)] = 1'b1;
         e1              = op_a[IW'(g)];
         e2              = op_b[IW'(g)];
         ec              = op_c[IW'(g)];
      end
      e_rsp = '0;
      if (m_rv[m_cyc] && !rst) e_rsp[IW'(m_ridx[m_cyc])] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("add_in1", 64'(add_in1), 64'(e1));
      chk("add_in2", 64'(add_in2), 64'(e2));
      chk("add_carry_in", 64'(add_carry_in), 64'(ec));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      if (m_rv[m_cyc] && !rst) chk("rsp_result", 64'({rsp_carry_out, rsp_sum}), 64'(m_rsum[m_cyc]));
      chk("idle", 64'(idle), 64'(m_halted));

      if (rst) begin
         m_ptr      = 0;
         m_draining = 1'b0;
         m_halted   = 1'b0;
         for (int k = 1; k <= LAT; k++) begin
            s       = m_cyc + 8'(k);
            m_rv[s] = 1'b0;
         end
      end else begin
         if (g >= 0) begin
            m_ptr     = (g + 1) % NR;
            full      = {1'b0, op_a[IW'(g)]} + {1'b0, op_b[IW'(g)]} + (DW + 1)'(op_c[IW'(g)]);
            s         = m_cyc + 8'(LAT);
            m_rv[s]   = 1'b1;
            m_ridx[s] = g;
            m_rsum[s] = full;
         end
         pending = 1'b0;
         for (int k = 1; k <= LAT; k++) begin
            s = m_cyc + 8'(k);
            if (m_rv[s]) pending = 1'b1;
         end
         if (!m_draining && !m_halted) begin
            if (p) m_draining = 1'b1;
         end else if (m_draining) begin
            if (!p) begin
               m_draining = 1'b0;
            end else if (!pending) begin
               m_draining = 1'b0;
               m_halted   = 1'b1;
            end
         end else if (!p) begin
            m_halted = 1'b0;
         end
      end
      m_rv[m_cyc] = 1'b0;
      @(posedge clock);
      m_cyc = m_cyc + 8'd1;
      @(negedge clock);
   endtask

   initial begin
      reset        = 1'b1;
      pause        = 1'b0;
      req_valid    = '0;
      req_in1      = '0;
      req_in2      = '0;
      req_carry_in = '0;
      m_ptr        = 0;
      m_draining   = 1'b0;
      m_halted     = 1'b0;
      m_cyc        = '0;
      for (int i = 0; i < NR; i++) begin
         op_a[IW'(i)] = '0;
         op_b[IW'(i)] = '0;
         op_c[IW'(i)] = 1'b0;
      end
      repeat (3) @(posedge clock);
      @(negedge clock);

      // Reset state: no grant even with every requester valid.
      step('1, 1'b0, 1'b1);
      step('0, 1'b0, 1'b0);

      // Directed single operations from requesters 0, 1, 2.
      op_a[0] = 32'd5;          op_b[0] = 32'd10;         op_c[0] = 1'b0;
      step(4'b0001, 1'b0, 1'b0);
      repeat (2) step('0, 1'b0, 1'b0);
      op_a[1] = 32'h0000ABCD;   op_b[1] = 32'h00001234;   op_c[1] = 1'b1;
      step(4'b0010, 1'b0, 1'b0);
      repeat (2) step('0, 1'b0, 1'b0);
      op_a[2] = 32'hFFFFFFFF;   op_b[2] = 32'hFFFFFFFF;   op_c[2] = 1'b0;
      step(4'b0100, 1'b0, 1'b0);
      repeat (2) step('0, 1'b0, 1'b0);

      // Bring the pointer back to 0, then all four requesters held for 8 cycles.
      rand_ops();
      step(4'b1000, 1'b0, 1'b0);
      repeat (8) begin
         rand_ops();
         step(4'b1111, 1'b0, 1'b0);
      end
      repeat (2) step('0, 1'b0, 1'b0);

      // Random traffic with occasional pause.
      repeat (60) begin
         rand_ops();
         step(NR'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
      end
      repeat (3) step('0, 1'b0, 1'b0);

      // Back-to-back grants, pause held until halted, then resume.
      repeat (3) begin
         rand_ops();
         step(4'b1111, 1'b0, 1'b0);
      end
      repeat (6) begin
         rand_ops();
         step(4'b1111, 1'b1, 1'b0);
      end
      repeat (2) begin
         rand_ops();
         step(4'b1111, 1'b0, 1'b0);
      end
      repeat (3) step('0, 1'b0, 1'b0);

      // Reset one cycle after a grant: the adder still emits, but no response may be flagged.
      rand_ops();
      step(4'b0001, 1'b0, 1'b0);
      step('0, 1'b0, 1'b1);
      repeat (3) step('0, 1'b0, 1'b0);

      // Reset while halted, with pause still held afterwards.
      repeat (5) step(4'b0110, 1'b1, 1'b0);
      step(4'b0110, 1'b1, 1'b1);
      repeat (4) step(4'b0110, 1'b1, 1'b0);
      repeat (4) begin
         rand_ops();
         step(4'b0110, 1'b0, 1'b0);
      end
      repeat (3) step('0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
